// File: rtl/mipi_csi_pkt.sv
// CSI-2 byte-stream packet parser: splits each HS burst into header, payload and footer.
// Optional payload CRC-16 check is built only when MIPI_CSI_CRC_EN is defined.
module mipi_csi_pkt #(
  parameter logic [15:0] MAX_WC = 16'd4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [7:0]  data,
  output logic [1:0]  vc,
  output logic [5:0]  dt,
  output logic [15:0] wc,
  output logic        frame_start,
  output logic        frame_end,
  output logic        line_start,
  output logic        line_end,
  output logic        pkt_start,
  output logic        pix_we,
  output logic [7:0]  pix_data,
  output logic        pkt_end,
  output logic        pkt_err,
  output logic        crc_err,
  output logic [2:0]  dbg_state
);

  // we/data is a valid-only stream: a byte is consumed on every rising edge where we
  // is high; there is no backpressure, and a burst ends on the first we-low cycle.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_FOOTER  = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_we_q;
  logic [1:0]  r_idx;
  logic [15:0] r_cnt;
  logic [1:0]  r_vc;
  logic [5:0]  r_dt;
  logic [15:0] r_wc;
  logic        r_frame_start, r_frame_end, r_line_start, r_line_end;
  logic        r_pkt_start, r_pix_we, r_pkt_end, r_pkt_err;
  logic [7:0]  r_pix_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_we_q        <= 1'b1;   // forces a we-low cycle before the first DI after reset
      r_idx         <= 2'd0;
      r_cnt         <= 16'd0;
      r_vc          <= 2'd0;
      r_dt          <= 6'd0;
      r_wc          <= 16'd0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_line_start  <= 1'b0;
      r_line_end    <= 1'b0;
      r_pkt_start   <= 1'b0;
      r_pix_we      <= 1'b0;
      r_pix_data    <= 8'd0;
      r_pkt_end     <= 1'b0;
      r_pkt_err     <= 1'b0;
    end else begin
      r_we_q        <= we;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_line_start  <= 1'b0;
      r_line_end    <= 1'b0;
      r_pkt_start   <= 1'b0;
      r_pix_we      <= 1'b0;
      r_pkt_end     <= 1'b0;
      r_pkt_err     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (we && !r_we_q) begin
            r_vc    <= data[7:6];
            r_dt    <= data[5:0];
            r_idx   <= 2'd1;
            r_state <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (!we) begin
            r_pkt_err <= 1'b1;
            r_state   <= ST_IDLE;
          end else if (r_idx == 2'd1) begin
            r_wc[7:0] <= data;
            r_idx     <= 2'd2;
          end else if (r_idx == 2'd2) begin
            r_wc[15:8] <= data;
            r_idx      <= 2'd3;
          end else if (r_dt <= 6'h0F) begin
            case (r_dt)
              6'h00:   r_frame_start <= 1'b1;
              6'h01:   r_frame_end   <= 1'b1;
              6'h02:   r_line_start  <= 1'b1;
              6'h03:   r_line_end    <= 1'b1;
              default: ;
            endcase
            r_state <= ST_DRAIN;
          end else if (r_wc > MAX_WC) begin
            r_pkt_err <= 1'b1;
            r_state   <= ST_DRAIN;
          end else begin
            r_pkt_start <= 1'b1;
            r_cnt       <= r_wc;
            r_idx       <= 2'd0;
            r_state     <= (r_wc == 16'd0) ? ST_FOOTER : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (!we) begin
            r_pkt_err <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_pix_we   <= 1'b1;
            r_pix_data <= data;
            r_cnt      <= r_cnt - 16'd1;
            if (r_cnt == 16'd1) r_state <= ST_FOOTER;
          end
        end
        ST_FOOTER: begin
          if (!we) begin
            r_pkt_err <= 1'b1;
            r_state   <= ST_IDLE;
          end else if (r_idx == 2'd0) begin
            r_idx <= 2'd1;
          end else begin
            r_pkt_end <= 1'b1;
            r_state   <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!we) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef MIPI_CSI_CRC_EN
  logic [15:0] r_crc;
  logic [7:0]  r_foot_lo;
  logic        r_crc_err;

  // Reflected CRC-16/CCITT (0x1021 bit-reversed to 0x8408), bytes fed LSB first.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] n;
    n = c;
    for (int i = 0; i < 8; i++) begin
      if (n[0] ^ b[i]) n = (n >> 1) ^ 16'h8408;
      else             n = n >> 1;
    end
    return n;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_crc     <= 16'hFFFF;
      r_foot_lo <= 8'd0;
      r_crc_err <= 1'b0;
    end else begin
      r_crc_err <= 1'b0;
      if (r_state == ST_HDR && we && r_idx == 2'd3) r_crc <= 16'hFFFF;
      if (r_state == ST_PAYLOAD && we) r_crc <= crc_byte(r_crc, data);
      if (r_state == ST_FOOTER && we) begin
        if (r_idx == 2'd0) r_foot_lo <= data;
        else               r_crc_err <= ({data, r_foot_lo} != r_crc);
      end
    end
  end

  assign crc_err = r_crc_err;
`else
  assign crc_err = 1'b0;
`endif

  assign vc          = r_vc;
  assign dt          = r_dt;
  assign wc          = r_wc;
  assign frame_start = r_frame_start;
  assign frame_end   = r_frame_end;
  assign line_start  = r_line_start;
  assign line_end    = r_line_end;
  assign pkt_start   = r_pkt_start;
  assign pix_we      = r_pix_we;
  assign pix_data    = r_pix_data;
  assign pkt_end     = r_pkt_end;
  assign pkt_err     = r_pkt_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_mipi_csi_pkt.sv
// Bench for mipi_csi_pkt: drives CSI bursts, scoreboards payload bytes and counts pulses.
module tb_mipi_csi_pkt;

  logic        clk = 1'b0;
  logic        reset, we;
  logic [7:0]  data;
  logic [1:0]  vc;
  logic [5:0]  dt;
  logic [15:0] wc;
  logic        frame_start, frame_end, line_start, line_end;
  logic        pkt_start, pix_we, pkt_end, pkt_err, crc_err;
  logic [7:0]  pix_data;
  logic [2:0]  dbg_state;

`ifdef MIPI_CSI_CRC_EN
  localparam int CRC_ON = 1;
`else
  localparam int CRC_ON = 0;
`endif

  mipi_csi_pkt #(.MAX_WC(16'd4096)) dut (
    .clk(clk), .reset(reset), .we(we), .data(data),
    .vc(vc), .dt(dt), .wc(wc),
    .frame_start(frame_start), .frame_end(frame_end),
    .line_start(line_start), .line_end(line_end),
    .pkt_start(pkt_start), .pix_we(pix_we), .pix_data(pix_data),
    .pkt_end(pkt_end), .pkt_err(pkt_err), .crc_err(crc_err),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [7:0] exp_q[$];
  int         lat_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int c_fs = 0, c_fe = 0, c_ls = 0, c_le = 0, c_ps = 0, c_pe = 0, c_er = 0, c_ce = 0, c_ce_alone = 0;

  logic [7:0] vec[24] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
                          8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
                          8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] n;
    n = c;
    for (int i = 0; i < 8; i++) begin
      if (n[0] ^ b[i]) n = (n >> 1) ^ 16'h8408;
      else             n = n >> 1;
    end
    return n;
  endfunction

  // monitor: payload bytes against the expected queue, pulse counters
  always @(negedge clk) begin
    if (pix_we === 1'b1) begin
      chk("pix_avail", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        chk("pix_data", 32'(pix_data), 32'(exp_q.pop_front()));
        chk("pix_lat", cyc, lat_q.pop_front());
      end
    end
    if (frame_start === 1'b1) c_fs++;
    if (frame_end   === 1'b1) c_fe++;
    if (line_start  === 1'b1) c_ls++;
    if (line_end    === 1'b1) c_le++;
    if (pkt_start   === 1'b1) c_ps++;
    if (pkt_end     === 1'b1) c_pe++;
    if (pkt_err     === 1'b1) c_er++;
    if (crc_err     === 1'b1) c_ce++;
    if (crc_err === 1'b1 && pkt_end !== 1'b1) c_ce_alone++;
  end

  // driver tasks
  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    we   = 1'b1;
    data = b;
  endtask

  task automatic send_pay(input logic [7:0] b);
    send(b);
    exp_q.push_back(b);
    lat_q.push_back(cyc + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      we   = 1'b0;
      data = 8'($urandom);
    end
  endtask

  task automatic hdr(input logic [7:0] di, input logic [15:0] w);
    send(di);
    send(w[7:0]);
    send(w[15:8]);
    send(8'($urandom));
  endtask

  task automatic long_pkt(input logic [7:0] di, input int n, input bit bad);
    logic [15:0] c;
    logic [7:0]  b;
    hdr(di, 16'(n));
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      send_pay(b);
      c = crc_upd(c, b);
    end
    if (bad) c = c ^ 16'h0100;
    send(c[7:0]);
    send(c[15:8]);
    idle(3);
  endtask

  task automatic counts(input string tag, input int fs, input int fe, input int ls, input int le,
                        input int ps, input int pe, input int er, input int ce);
    chk({tag, ".frame_start"}, c_fs, fs);
    chk({tag, ".frame_end"},   c_fe, fe);
    chk({tag, ".line_start"},  c_ls, ls);
    chk({tag, ".line_end"},    c_le, le);
    chk({tag, ".pkt_start"},   c_ps, ps);
    chk({tag, ".pkt_end"},     c_pe, pe);
    chk({tag, ".pkt_err"},     c_er, er);
    chk({tag, ".crc_err"},     c_ce, ce);
    chk({tag, ".crc_alone"},   c_ce_alone, 0);
    chk({tag, ".sb_empty"},    32'(exp_q.size()), 32'd0);
    c_fs = 0; c_fe = 0; c_ls = 0; c_le = 0; c_ps = 0; c_pe = 0; c_er = 0; c_ce = 0; c_ce_alone = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".outs"}, 32'({vc, dt, wc, pix_data}), 32'd0);
    chk({tag, ".pulses"}, 32'({frame_start, frame_end, line_start, line_end, pkt_start,
                               pix_we, pkt_end, pkt_err, crc_err}), 32'd0);
    chk({tag, ".state"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    logic [5:0] sdt[4] = '{6'h01, 6'h02, 6'h03, 6'h08};
    logic [15:0] w;
    reset = 1'b1; we = 1'b0; data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);
    counts("reset", 0, 0, 0, 0, 0, 0, 0, 0);

    // frame start short packet
    hdr(8'h00, 16'h0001);
    idle(3);
    chk("fs.vc", 32'(vc), 32'd0);
    chk("fs.dt", 32'(dt), 32'h00);
    chk("fs.wc", 32'(wc), 32'h0001);
    chk("fs.state", 32'(dbg_state), 32'd0);
    counts("fs", 1, 0, 0, 0, 0, 0, 0, 0);

    // other short data types, including a reserved one with no pulse
    for (int k = 0; k < 4; k++) begin
      w = 16'($urandom);
      hdr({2'b10, sdt[k]}, w);
      idle(2);
      chk("short.vc", 32'(vc), 32'd2);
      chk("short.dt", 32'(dt), 32'(sdt[k]));
      chk("short.wc", 32'(wc), 32'(w));
      counts("short", 0, int'(sdt[k] == 6'h01), int'(sdt[k] == 6'h02), int'(sdt[k] == 6'h03),
             0, 0, 0, 0);
    end

    // reference vector, good and corrupted footer
    for (int k = 0; k < 2; k++) begin
      hdr(8'h6A, 16'h0018);
      for (int i = 0; i < 24; i++) send_pay(vec[i]);
      send((k == 0) ? 8'hF0 : 8'hF1);
      send(8'h00);
      idle(3);
      chk("vec.vc", 32'(vc), 32'd1);
      chk("vec.dt", 32'(dt), 32'h2A);
      chk("vec.wc", 32'(wc), 32'h0018);
      counts((k == 0) ? "vec_good" : "vec_bad", 0, 0, 0, 0, 1, 1, 0, (k == 0) ? 0 : CRC_ON);
    end

    // we drops after 5 of 16 payload bytes, then a normal packet
    hdr(8'h2A, 16'h0010);
    for (int i = 0; i < 5; i++) send_pay(8'($urandom));
    idle(3);
    counts("trunc", 0, 0, 0, 0, 1, 0, 1, 0);
    long_pkt(8'hDE, 7, 1'b0);
    counts("after_trunc", 0, 0, 0, 0, 1, 1, 0, 0);

    // word count above MAX_WC
    hdr(8'h2A, 16'h1001);
    send(8'h11);
    @(negedge clk);
    chk("big.state", 32'(dbg_state), 32'd4);
    send(8'h22);
    idle(3);
    chk("big.wc", 32'(wc), 32'h1001);
    counts("big_wc", 0, 0, 0, 0, 0, 0, 1, 0);

    // MAX_WC itself is still accepted: header only, payload abandoned via we low
    hdr(8'h2B, 16'd4096);
    send_pay(8'h5A);
    idle(3);
    counts("max_wc", 0, 0, 0, 0, 1, 0, 1, 0);

    // zero-length long packet
    hdr(8'h2A, 16'h0000); send(8'hFF); send(8'hFF); idle(3);
    counts("wc0_good", 0, 0, 0, 0, 1, 1, 0, 0);
    hdr(8'h2A, 16'h0000); send(8'h00); send(8'h00); idle(3);
    counts("wc0_bad", 0, 0, 0, 0, 1, 1, 0, CRC_ON);

    // random long packets
    for (int k = 0; k < 4; k++) begin
      long_pkt({2'($urandom), 6'($urandom_range(16, 63))}, $urandom_range(1, 20), k[0]);
      counts("rand", 0, 0, 0, 0, 1, 1, 0, k[0] ? CRC_ON : 0);
    end

    // reset mid-payload with we held high through and past reset
    hdr(8'h2C, 16'h0010);
    for (int i = 0; i < 3; i++) send_pay(8'($urandom));
    @(posedge clk); #1;
    reset = 1'b1;
    data  = 8'h02;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) check_zero("mid_reset");
    end
    @(posedge clk); #1;
    reset = 1'b0;
    send(8'h02); send(8'h00);
    idle(1);
    hdr(8'h02, 16'h0000);
    idle(3);
    counts("reset_mid", 0, 0, 1, 0, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mipi_csi_pkt.md
MIPI_CSI_PKT -- requirements
Module: mipi_csi_pkt

Interface
REQ-001 SHALL have parameter MAX_WC, default 16'd4096, meaning the largest accepted long-packet word count; larger counts abort the packet.
REQ-002 SHALL have port clk, input, 1, byte clock from the deserializer; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port we, input, 1, byte valid from the deserializer, high for the whole HS burst.
REQ-005 SHALL have port data, input, 8, deserialized, word-aligned byte; the first we-high byte of a burst is the Data Identifier (DI).
REQ-006 SHALL have port vc, output, 2, virtual channel DI[7:6] of the current or last packet.
REQ-007 SHALL have port dt, output, 6, data type DI[5:0] of the current or last packet.
REQ-008 SHALL have port wc, output, 16, header word count, or short-packet data field.
REQ-009 SHALL have ports frame_start, frame_end, line_start, line_end, output, 1 each, one-cycle short-packet pulses.
REQ-010 SHALL have port pkt_start, output, 1, one-cycle pulse at the start of each long packet.
REQ-011 SHALL have port pix_we, output, 1, payload byte valid.
REQ-012 SHALL have port pix_data, output, 8, payload byte.
REQ-013 SHALL have port pkt_end, output, 1, one-cycle pulse after a long packet's last footer byte.
REQ-014 SHALL have ports pkt_err and crc_err, output, 1 each, one-cycle error pulses.

Function
REQ-015 SHALL implement the states IDLE, HDR, PAYLOAD, FOOTER and DRAIN.
REQ-016 IDLE: on a we-high byte, latch the byte as DI and go to HDR with byte index 1.
REQ-017 HDR: latch byte 1 as wc[7:0] and byte 2 as wc[15:8]; byte 3 (ECC) is ignored.
REQ-018 Packet class: dt <= 6'h0F is a short packet; anything else is a long packet.
REQ-019 After header byte 3 of a short packet: pulse frame_start, frame_end, line_start or line_end for dt 0x00, 0x01, 0x02 or 0x03 respectively (other short dt values produce no pulse); then go to DRAIN.
REQ-020 After header byte 3 of a long packet: pulse pkt_start; load the byte counter with wc; go to PAYLOAD, or straight to FOOTER if wc == 0.
REQ-021 If wc > MAX_WC after header byte 3 of a long packet: pulse pkt_err, issue no pkt_start, go to DRAIN.
REQ-022 PAYLOAD: each we-high byte sets pix_data and asserts pix_we on the following cycle (latency 1) and decrements the counter; after the byte that makes the counter 0, go to FOOTER.
REQ-023 FOOTER: capture 2 bytes, LSB first; pulse pkt_end the cycle after the second byte; go to DRAIN.
REQ-024 DRAIN: ignore all bytes while we is high; go to IDLE on the first we-low cycle.
REQ-025 we low in HDR, PAYLOAD or FOOTER: pulse pkt_err, issue no pkt_end, go to IDLE; bytes already output are not retracted.
REQ-026 we low in IDLE: remain in IDLE.
REQ-027 A new burst is recognised only after at least one we-low cycle.
REQ-028 vc, dt and wc SHALL update when the corresponding header byte is latched and hold until the next packet.

Reset
REQ-029 While reset is high, state SHALL be IDLE, vc, dt, wc and pix_data SHALL be 0, and all pulse outputs and pix_we SHALL be 0.
REQ-030 Reset asserted mid-packet SHALL abort the packet with no pkt_err, pkt_end or crc_err pulse; the next packet is parsed only from a fresh burst after reset releases.

Configuration
REQ-031 With MIPI_CSI_CRC_EN defined: compute CRC-16 (poly x^16+x^12+x^5+1, init 0xFFFF, LSB-first per byte) over the payload bytes.
REQ-032 With MIPI_CSI_CRC_EN defined: compare the CRC against the footer and pulse crc_err together with pkt_end on mismatch.
REQ-033 With MIPI_CSI_CRC_EN defined: for wc == 0, the expected CRC is 0xFFFF.
REQ-034 Without MIPI_CSI_CRC_EN: no CRC logic is present, crc_err is tied to 0, and footer bytes are consumed and discarded.

Verification
REQ-035 Burst 00 01 00 xx, then we low -> frame_start pulses once with vc=0, dt=0x00 and wc=0x0001; state returns to IDLE.
REQ-036 Burst 6A 18 00 xx, 24-byte payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01, footer F0 00 -> pkt_start; 24 pix_we bytes in order, each 1 cycle after input; pkt_end; crc_err=0 with CRC_EN.
REQ-037 Same burst as REQ-036 with footer F1 00 -> crc_err pulses with pkt_end when CRC_EN is defined, and stays 0 without it.
REQ-038 Long header with wc=0x0010 where we drops after 5 payload bytes -> exactly 5 pix_we, one pkt_err pulse, no pkt_end; the next burst parses normally.
REQ-039 Header 2A 01 10 xx with MAX_WC=4096 -> pkt_err pulses, no pix_we, DRAIN until we low.
REQ-040 reset pulsed mid-payload, then a new 02 00 00 xx burst -> outputs are 0 during reset, then a single line_start pulse.
